// File: rtl/qbert_move_ctrl.sv
// Q*bert move controller: turns direction/tilt requests into jump or saucer commands
// for the animation layer and keeps position, visited cubes, lives and score.
module qbert_move_ctrl #(
    parameter int N_CUBE      = 28,
    parameter int LIVES_INIT  = 3,
    parameter int ACK_TIMEOUT = 1024,
    parameter int SCORE_STEP  = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dir_valid,
    input  logic [2:0]        dir_req,
    input  logic [1:0]        tilt_req,
    input  logic              game_pause,
    input  logic              game_restart,
    input  logic              done_move,
    input  logic [2:0]        state_qb,
    output logic [N_CUBE-1:0] position_qb,
    output logic [N_CUBE-1:0] e_next_qb,
    output logic [2:0]        e_jump_qb,
    output logic              e_bad_jump,
    output logic              e_win_qb,
    output logic [1:0]        e_tilt_acc,
    output logic [N_CUBE-1:0] cubes_done,
    output logic [2:0]        lives,
    output logic [15:0]       score,
    output logic              busy,
    output logic              game_over
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_MOVE, S_SETTLE, S_OVER} state_t;

    localparam logic [2:0]        QB_IDLE   = 3'd2;
    localparam logic [N_CUBE-1:0] TOP       = N_CUBE'(1);
    localparam logic [N_CUBE-1:0] ALL_CUBES = '1;
    localparam int                TW        = $clog2(ACK_TIMEOUT) + 1;

    state_t          state, state_nxt;
    logic [TW-1:0]   tmo_cnt;
    logic [2:0]      cur_r, cur_k, t_r, t_k;
    logic            t_ok, dir_ok, tilt_ok, accept;
    logic [N_CUBE-1:0] tgt;
    logic            issue_tilt, issue_jump, tmo, land, settle_done;
    logic [16:0]     score_sum;
    logic            is_new;

    function automatic logic [4:0] row_base(input logic [2:0] r);
        case (r)
            3'd2:    return 5'd1;
            3'd3:    return 5'd3;
            3'd4:    return 5'd6;
            3'd5:    return 5'd10;
            3'd6:    return 5'd15;
            3'd7:    return 5'd21;
            default: return 5'd0;
        endcase
    endfunction

    // Decode the one-hot position back to (row, column).
    always_comb begin
        cur_r = 3'd1;
        cur_k = 3'd0;
        for (int r = 1; r <= 7; r++)
            for (int k = 0; k < r; k++)
                if (position_qb[r*(r-1)/2+k]) begin
                    cur_r = 3'(r);
                    cur_k = 3'(k);
                end
    end

    always_comb begin
        t_r    = cur_r;
        t_k    = cur_k;
        t_ok   = 1'b0;
        dir_ok = 1'b1;
        case (dir_req)
            3'd1:    begin t_r = cur_r + 3'd1; t_k = cur_k;        t_ok = (cur_r != 3'd7); end
            3'd2:    begin t_r = cur_r + 3'd1; t_k = cur_k + 3'd1; t_ok = (cur_r != 3'd7); end
            3'd3:    begin t_r = cur_r - 3'd1; t_k = cur_k - 3'd1; t_ok = (cur_k != 3'd0); end
            3'd4:    begin t_r = cur_r - 3'd1; t_k = cur_k;        t_ok = (cur_k != cur_r - 3'd1); end
            default: dir_ok = 1'b0;
        endcase
        tgt = t_ok ? (TOP << (row_base(t_r) + {2'b00, t_k})) : '0;
    end

    assign tilt_ok   = (tilt_req == 2'd1 && cur_k == 3'd0) ||
                       (tilt_req == 2'd2 && cur_k == cur_r - 3'd1);
    assign accept    = !game_pause && !game_over && done_move && state_qb == QB_IDLE;
    assign score_sum = {1'b0, score} + 17'(SCORE_STEP);
    assign is_new    = ~|(cubes_done & e_next_qb);

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;

    always_comb begin
        state_nxt   = state;
        issue_tilt  = 1'b0;
        issue_jump  = 1'b0;
        tmo         = 1'b0;
        land        = 1'b0;
        settle_done = 1'b0;
        case (state)
            S_IDLE:
                if (accept) begin
                    if (tilt_ok) begin
                        issue_tilt = 1'b1;
                        state_nxt  = S_ISSUE;
                    end else if (dir_valid && dir_ok) begin
                        issue_jump = 1'b1;
                        state_nxt  = S_ISSUE;
                    end
                end
            S_ISSUE:
                if (!done_move) state_nxt = S_MOVE;
                else if (tmo_cnt == TW'(ACK_TIMEOUT - 1)) begin
                    tmo       = 1'b1;
                    state_nxt = S_IDLE;
                end
            S_MOVE:
                if (done_move) begin
                    land = 1'b1;
                    if (e_tilt_acc != 2'd0 || e_bad_jump) state_nxt = S_SETTLE;
                    else if (e_win_qb)                    state_nxt = S_OVER;
                    else                                  state_nxt = S_IDLE;
                end
            S_SETTLE:
                if (state_qb == QB_IDLE && done_move) begin
                    settle_done = 1'b1;
                    state_nxt   = (lives == 3'd0) ? S_OVER : S_IDLE;
                end
            default: state_nxt = state;
        endcase
        if (game_restart) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            position_qb <= TOP;  cubes_done <= TOP;  e_next_qb <= TOP;
            e_jump_qb   <= '0;   e_tilt_acc <= '0;   e_bad_jump <= 1'b0; e_win_qb <= 1'b0;
            lives       <= 3'(LIVES_INIT);           score <= '0;
            busy        <= 1'b0; game_over  <= 1'b0; tmo_cnt <= '0;
        end else if (game_restart) begin
            position_qb <= TOP;  cubes_done <= TOP;  e_next_qb <= TOP;
            e_jump_qb   <= '0;   e_tilt_acc <= '0;   e_bad_jump <= 1'b0; e_win_qb <= 1'b0;
            lives       <= 3'(LIVES_INIT);           score <= '0;
            busy        <= 1'b0; game_over  <= 1'b0; tmo_cnt <= '0;
        end else begin
            tmo_cnt <= (state == S_ISSUE) ? tmo_cnt + TW'(1) : '0;
            if (issue_tilt) begin
                e_tilt_acc <= tilt_req;  e_next_qb <= TOP;  e_jump_qb <= '0;
                e_bad_jump <= 1'b0;      e_win_qb  <= 1'b0; busy      <= 1'b1;
            end
            if (issue_jump) begin
                e_jump_qb  <= dir_req;   e_next_qb <= tgt;  e_tilt_acc <= '0;
                e_bad_jump <= !t_ok;
                e_win_qb   <= ((cubes_done | tgt) == ALL_CUBES) && t_ok;
                busy       <= 1'b1;
            end
            // Idle "no move pending" convention: target equals the current cube.
            if (tmo) begin
                e_jump_qb <= '0; e_tilt_acc <= '0; e_bad_jump <= 1'b0; e_win_qb <= 1'b0;
                e_next_qb <= position_qb; busy <= 1'b0;
            end
            if (land) begin
                if (e_tilt_acc != 2'd0 || e_bad_jump) begin
                    position_qb <= TOP;
                    if (e_bad_jump && lives != 3'd0) lives <= lives - 3'd1;
                end else begin
                    position_qb <= e_next_qb;
                    if (is_new) begin
                        cubes_done <= cubes_done | e_next_qb;
                        score      <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    end
                    busy <= 1'b0;
                    if (e_win_qb) game_over <= 1'b1;
                    else begin
                        e_jump_qb <= '0; e_tilt_acc <= '0; e_bad_jump <= 1'b0;
                    end
                end
            end
            if (settle_done) begin
                e_jump_qb <= '0; e_tilt_acc <= '0; e_bad_jump <= 1'b0; e_win_qb <= 1'b0;
                e_next_qb <= TOP; busy <= 1'b0;
                if (lives == 3'd0) game_over <= 1'b1;
            end
        end
    end
endmodule

// File: doc/qbert_move_ctrl.md
Name: qbert_move_ctrl

Overview:
- Command-side initiator of the Q*bert jump/saucer handshake; the qbert animation layer is the responder.
- Accepts direction and tilt requests from the NIOS/accelerometer path and tracks the one-hot cube position on the 28-cube pyramid.
- Computes the next cube, bad-jump and win flags, drives them to the animation layer and sequences on its done_move/state_qb feedback.
- Maintains the visited-cube mask, lives and score.

Parameters:
- N_CUBE, 28: cubes in the pyramid, 7 rows, one-hot position width; fixed at 28.
- LIVES_INIT, 3: lives loaded at reset/restart.
- ACK_TIMEOUT, 1024: cycles to wait for done_move to fall after a command is issued.
- SCORE_STEP, 25: points per newly visited cube.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- dir_valid  in  1  one-cycle pulse: dir_req valid.
- dir_req  in  3  1=DOWN_RIGHT, 2=DOWN_LEFT, 3=UP_RIGHT, 4=UP_LEFT; other codes ignored.
- tilt_req  in  2  0=none, 1=right saucer, 2=left saucer; level.
- game_pause  in  1  level; blocks new commands.
- game_restart  in  1  one-cycle pulse.
- done_move  in  1  responder move-complete level.
- state_qb  in  3  responder state: 0 START, 1 JUMP, 2 IDLE, 3 SAUCER, 4 KO.
- position_qb  out  28  one-hot current cube.
- e_next_qb  out  28  one-hot target cube; 0 = off pyramid.
- e_jump_qb  out  3  issued direction; 0 when no jump is pending.
- e_bad_jump  out  1  target is off pyramid.
- e_win_qb  out  1  target completes the visited mask.
- e_tilt_acc  out  2  issued saucer tilt.
- cubes_done  out  28  visited mask.
- lives  out  3  remaining lives.
- score  out  16  accumulated score; saturates at 16'hFFFF.
- busy  out  1  command in flight.
- game_over  out  1  lives exhausted or win.

Behaviour:
- Reset (async) and game_restart (sync):
  - position_qb=1, cubes_done=1, e_next_qb=1.
  - e_jump_qb=0, e_tilt_acc=0, e_bad_jump=0, e_win_qb=0.
  - lives=LIVES_INIT, score=0, busy=0, game_over=0.
  - FSM returns to IDLE. game_restart overrides any state.
- Geometry:
  - Row r (1..7), column k (0..r-1) maps to bit r(r-1)/2+k.
  - k=0 is the right edge; k=r-1 is the left edge.
- Target for each direction (illegal targets give e_next_qb=0 and e_bad_jump=1):
  - DOWN_RIGHT: (r+1,k); illegal if r=7.
  - DOWN_LEFT: (r+1,k+1); illegal if r=7.
  - UP_RIGHT: (r-1,k-1); illegal if k=0.
  - UP_LEFT: (r-1,k); illegal if k=r-1.
- FSM states: IDLE, ISSUE, MOVE, SETTLE, OVER.
- IDLE:
  - Accepts only when !game_pause && !game_over && done_move && state_qb==IDLE.
  - If tilt_req≠0 and tilt_req is legal, the saucer is issued; it takes priority over a same-cycle dir_valid.
    - Right tilt is legal on right-edge cubes (k=0, includes TOP); left tilt on left-edge cubes (k=r-1).
  - Otherwise a legal dir_valid is issued.
  - On issue, the registered outputs appear the next cycle together with busy=1, and the FSM goes to ISSUE.
    - Jump: e_jump_qb, e_next_qb, e_bad_jump are driven; e_win_qb = ((cubes_done|e_next_qb)==all ones) && !e_bad_jump.
    - Saucer: e_tilt_acc and e_next_qb=1 are driven.
  - Requests arriving while not accepting are dropped, not queued.
- ISSUE:
  - Waits for done_move=0, then goes to MOVE.
  - If the timeout counter reaches ACK_TIMEOUT first, all command outputs clear, busy=0, and the FSM returns to IDLE with position unchanged.
- MOVE:
  - Waits for done_move=1.
  - Good landing: position_qb<=e_next_qb. If the cube is new, set its cubes_done bit and add SCORE_STEP.
  - Win: go to OVER, game_over=1.
  - Bad jump: lives decrements (floor 0), position_qb<=1, then SETTLE.
  - Saucer: position_qb<=1, then SETTLE.
  - Good jump without win: clear command outputs and return to IDLE.
- SETTLE:
  - Holds command outputs until state_qb==IDLE && done_move, then clears them.
  - Goes to OVER if lives==0, else IDLE.
- OVER: holds all outputs; busy=0; exits only on game_restart.
- Invariant: position_qb is always exactly one-hot.

Test Plan:
- Reset, then DOWN_RIGHT from TOP with responder ack -> e_next_qb=0x2, e_bad_jump=0; after done_move rises, position_qb=0x2, cubes_done=0x3, score=25.
- Bad jump: from bit 21 (row7,k=0) issue DOWN_LEFT -> e_next_qb=0, e_bad_jump=1. After KO/START complete and state_qb=IDLE, lives=2 and position_qb=1.
- Saucer: tilt_req=1 at R04 (0x8) -> e_tilt_acc=1. Same tilt at center cube bit4 -> ignored, busy stays 0.
- Win: visit 27 cubes, final jump onto the last cube -> e_win_qb=1 with the command; after landing, game_over=1, cubes_done=0x0FFFFFFF.
- Timeout: issue a jump and hold done_move=1 for 1024 cycles -> outputs cleared, busy=0, position unchanged.
- game_pause=1 blocks dir_valid; reset asserted in MOVE -> all outputs back to reset values immediately.
